// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master (instruction fetch / load-store) front end for the
// unified 32-bit memory. It arbitrates in IDLE and runs each granted burst as
// back-to-back single-word accesses. Read data returns through a short
// pipeline that tracks which port owns each returning beat.
module mem_arbiter #(
    parameter int READ_LAT     = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    input  logic [1:0]  f_size,
    output logic        f_gnt,
    output logic        f_rvalid,
    output logic [31:0] f_rdata,
    output logic        f_done,
    input  logic        d_req,
    input  logic        d_rw,
    input  logic [31:0] d_addr,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_wdata,
    output logic        d_wready,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        ctrl_busy,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    output logic [1:0]  mem_access_size,
    output logic        mem_rw,
    output logic        mem_enable,
    input  logic [31:0] mem_data_out
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BURST = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [1:0]          state;
    logic                gnt_f_p1;    // grant pulse, also the setup cycle of BURST
    logic                gnt_d_p1;
    logic                own_d;       // 1: load/store port owns the burst
    logic                rw_p1;       // latched direction, 1 = read
    logic [31:0]         base_p1;     // word-aligned start address
    logic [3:0]          last_p1;     // index of the final beat
    logic [3:0]          beat_cnt;
    logic [SW-1:0]       starve_cnt;
    logic                wdone_p1;    // write burst finished last cycle
    logic [READ_LAT-1:0] rd_vld;
    logic [READ_LAT-1:0] rd_last;
    logic [READ_LAT-1:0] rd_own;

    logic pick_f;
    logic pick_d;
    logic beat;
    logic last_beat;
    logic rd_ret;

    // Burst size code to index of last beat: 1/4/8/16 words.
    function automatic logic [3:0] size_to_last(input logic [1:0] size);
        case (size)
            2'b00:   size_to_last = 4'd0;
            2'b01:   size_to_last = 4'd3;
            2'b10:   size_to_last = 4'd7;
            default: size_to_last = 4'd15;
        endcase
    endfunction

    // Arbitration: data normally wins a tie, fetch wins once it has starved.
    always_comb begin
        pick_f = 1'b0;
        pick_d = 1'b0;
        if (state == IDLE) begin
            if (f_req && d_req) begin
                if (starve_cnt == STARVE_MAX) pick_f = 1'b1;
                else                          pick_d = 1'b1;
            end else if (f_req) begin
                pick_f = 1'b1;
            end else if (d_req) begin
                pick_d = 1'b1;
            end
        end
    end

    // The grant cycle sits at the front of BURST and issues no beat.
    assign beat      = (state == BURST) && !(gnt_f_p1 || gnt_d_p1);
    assign last_beat = beat && (beat_cnt == last_p1);
    assign rd_ret    = rd_vld[READ_LAT-1];

    // Control state: FSM, beat and starve counters, read-return tracking.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            gnt_f_p1   <= 1'b0;
            gnt_d_p1   <= 1'b0;
            own_d      <= 1'b0;
            beat_cnt   <= 4'd0;
            starve_cnt <= '0;
            wdone_p1   <= 1'b0;
            rd_vld     <= '0;
            rd_last    <= '0;
            rd_own     <= '0;
        end else begin
            gnt_f_p1 <= pick_f;
            gnt_d_p1 <= pick_d;
            wdone_p1 <= last_beat && !rw_p1;

            if (pick_f) begin
                starve_cnt <= '0;
            end else if (pick_d && f_req && (starve_cnt < STARVE_MAX)) begin
                starve_cnt <= starve_cnt + SW'(1);
            end

            case (state)
                IDLE: begin
                    beat_cnt <= 4'd0;
                    if (pick_f || pick_d) begin
                        state <= BURST;
                        own_d <= pick_d;
                    end
                end
                BURST: begin
                    if (last_beat) begin
                        beat_cnt <= 4'd0;
                        state    <= rw_p1 ? DRAIN : IDLE;
                    end else if (beat) begin
                        beat_cnt <= beat_cnt + 4'd1;
                    end
                end
                DRAIN: begin
                    if (rd_ret && rd_last[READ_LAT-1]) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            rd_vld[0]  <= beat && rw_p1;
            rd_last[0] <= last_beat;
            rd_own[0]  <= own_d;
            for (int i = 1; i < READ_LAT; i++) begin
                rd_vld[i]  <= rd_vld[i-1];
                rd_last[i] <= rd_last[i-1];
                rd_own[i]  <= rd_own[i-1];
            end
        end
    end

    // Request attributes of the winner; only read while a burst is active.
    always_ff @(posedge clock) begin
        if (pick_f) begin
            base_p1 <= f_addr & 32'hFFFF_FFFC;
            rw_p1   <= 1'b1;
            last_p1 <= size_to_last(f_size);
        end else if (pick_d) begin
            base_p1 <= d_addr & 32'hFFFF_FFFC;
            rw_p1   <= d_rw;
            last_p1 <= size_to_last(d_size);
        end
    end

    assign ctrl_busy       = (state != IDLE);
    assign mem_access_size = 2'b00;
    assign mem_enable      = beat;
    assign mem_rw          = beat && rw_p1;
    assign mem_addr        = beat ? (base_p1 + {26'd0, beat_cnt, 2'b00}) : 32'd0;
    assign mem_data_in     = (beat && !rw_p1) ? d_wdata : 32'd0;
    assign d_wready        = beat && !rw_p1 && own_d;

    assign f_gnt    = gnt_f_p1;
    assign d_gnt    = gnt_d_p1;
    assign f_rvalid = rd_ret && !rd_own[READ_LAT-1];
    assign d_rvalid = rd_ret && rd_own[READ_LAT-1];
    assign f_rdata  = f_rvalid ? mem_data_out : 32'd0;
    assign d_rdata  = d_rvalid ? mem_data_out : 32'd0;
    assign f_done   = f_rvalid && rd_last[READ_LAT-1];
    assign d_done   = wdone_p1 || (d_rvalid && rd_last[READ_LAT-1]);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a one-cycle-latency
// memory model that returns (mem_key ^ address) for every read beat.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        f_req, d_req, d_rw;
    logic [31:0] f_addr, d_addr, d_wdata;
    logic [1:0]  f_size, d_size;
    logic        f_gnt, f_rvalid, f_done;
    logic [31:0] f_rdata;
    logic        d_wready, d_gnt, d_rvalid, d_done;
    logic [31:0] d_rdata;
    logic        ctrl_busy;
    logic [31:0] mem_addr, mem_data_in;
    logic [1:0]  mem_access_size;
    logic        mem_rw, mem_enable;
    logic [31:0] mem_data_out = 32'd0;
    logic [31:0] mem_key = 32'd0;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [9:0]  seq;
    int          g, ovl, cyc, rv, beats, dn_cnt, dn_at, fx, fr, dg;
    logic [31:0] a4;

    mem_arbiter dut (
        .clock(clock), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_size(f_size), .f_gnt(f_gnt),
        .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_done(f_done),
        .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_size(d_size),
        .d_wdata(d_wdata), .d_wready(d_wready), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_done(d_done),
        .ctrl_busy(ctrl_busy), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_access_size(mem_access_size), .mem_rw(mem_rw),
        .mem_enable(mem_enable), .mem_data_out(mem_data_out)
    );

    always #5 clock = ~clock;

    // Memory model, read latency of one cycle.
    always @(posedge clock) begin
        if (mem_enable && mem_rw) mem_data_out <= mem_key ^ mem_addr;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; f_req = 0; d_req = 0; d_rw = 0;
        f_addr = 0; d_addr = 0; d_wdata = 0; f_size = 0; d_size = 0;
        tick; tick;
        check("rst_busy", ctrl_busy, 0);
        check("rst_men", mem_enable, 0);
        check("rst_gnt", {f_gnt, d_gnt}, 0);
        check("rst_outs", {f_rvalid, d_rvalid, f_done, d_done, d_wready, mem_rw}, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_size", mem_access_size, 0);
        reset = 1'b0;
        tick;

        // Single-word fetch
        mem_key = 32'h5EAFBEEF;
        f_req = 1; f_addr = 32'h80020000; f_size = 2'b00;
        tick;
        check("t1_fgnt", f_gnt, 1);
        check("t1_dgnt", d_gnt, 0);
        f_req = 0;
        tick;
        check("t1_men", mem_enable, 1);
        check("t1_addr", mem_addr, 32'h80020000);
        check("t1_rw", mem_rw, 1);
        tick;
        check("t1_rvalid", f_rvalid, 1);
        check("t1_done", f_done, 1);
        check("t1_rdata", f_rdata, 32'hDEADBEEF);
        check("t1_drvalid", d_rvalid, 0);
        tick;
        check("t1_idle", ctrl_busy, 0);
        check("t1_rv_off", f_rvalid, 0);

        // Four-word write, misaligned base
        d_req = 1; d_rw = 0; d_addr = 32'h80020013; d_size = 2'b01;
        tick;
        check("t2_dgnt", d_gnt, 1);
        d_req = 0;
        d_wdata = 32'd1;
        for (int k = 0; k < 4; k++) begin
            tick;
            check("t2_addr", mem_addr, 32'h80020010 + 32'(k * 4));
            check("t2_rw", mem_rw, 0);
            check("t2_men", mem_enable, 1);
            check("t2_wdata", mem_data_in, 32'(k + 1));
            check("t2_wready", d_wready, 1);
            check("t2_early_done", d_done, 0);
            d_wdata = 32'(k + 2);
        end
        tick;
        check("t2_done", d_done, 1);
        check("t2_wready_off", d_wready, 0);
        check("t2_men_off", mem_enable, 0);
        tick;
        check("t2_done_pulse", d_done, 0);

        // Both ports requesting continuously
        mem_key = 32'd0;
        f_addr = 32'h100; f_size = 0;
        d_addr = 32'h200; d_rw = 1; d_size = 0;
        f_req = 1; d_req = 1;
        seq = '0; g = 0; ovl = 0; cyc = 0;
        while (g < 10 && cyc < 300) begin
            tick;
            cyc++;
            if (f_gnt || d_gnt) begin
                if (f_gnt && d_gnt) ovl++;
                if (mem_enable || f_rvalid || d_rvalid) ovl++;
                seq[g] = f_gnt;
                g++;
            end
        end
        f_req = 0; d_req = 0;
        check("t3_grants", g, 10);
        check("t3_order", 32'(seq), 32'h210);
        check("t3_overlap", ovl, 0);
        repeat (6) tick;
        check("t3_idle", ctrl_busy, 0);

        // Sixteen-word read wrapping past the top of memory
        mem_key = 32'h13579BDF;
        d_req = 1; d_rw = 1; d_addr = 32'hFFFFFFF0; d_size = 2'b11;
        tick;
        check("t4_dgnt", d_gnt, 1);
        d_req = 0;
        rv = 0; beats = 0; a4 = 32'hDEAD0000; dn_cnt = 0; dn_at = -1; fx = 0;
        repeat (22) begin
            tick;
            if (mem_enable) begin
                if (beats == 4) a4 = mem_addr;
                beats++;
            end
            if (d_rvalid) begin
                check("t4_rdata", d_rdata, mem_key ^ (32'hFFFFFFF0 + 32'(rv * 4)));
                rv++;
            end
            if (d_done) begin
                dn_cnt++;
                dn_at = rv;
            end
            if (f_rvalid || f_done) fx++;
        end
        check("t4_beats", beats, 16);
        check("t4_wrap", a4, 32'h00000000);
        check("t4_rvalids", rv, 16);
        check("t4_done_cnt", dn_cnt, 1);
        check("t4_done_at", dn_at, 16);
        check("t4_fetch_quiet", fx, 0);
        check("t4_idle", ctrl_busy, 0);

        // Reset in the middle of an eight-word fetch
        mem_key = 32'd0;
        f_req = 1; f_addr = 32'h1000; f_size = 2'b10;
        tick;
        check("t5_fgnt", f_gnt, 1);
        f_req = 0;
        tick;
        repeat (5) tick;
        check("t5_beat5", mem_addr, 32'h1014);
        #2 reset = 1'b1;
        #1;
        check("t5_men", mem_enable, 0);
        check("t5_addr", mem_addr, 0);
        check("t5_rv", {f_rvalid, f_done}, 0);
        check("t5_rdata", f_rdata, 0);
        check("t5_busy", ctrl_busy, 0);
        @(posedge clock);
        #1 reset = 1'b0;
        fr = 0;
        repeat (12) begin
            tick;
            if (f_rvalid || f_done) fr++;
        end
        check("t5_no_ret", fr, 0);
        mem_key = 32'hA5A5A5A5;
        d_req = 1; d_rw = 1; d_addr = 32'h40; d_size = 0;
        tick;
        check("t5_dgnt", d_gnt, 1);
        d_req = 0;
        tick;
        tick;
        check("t5_drv", d_rvalid, 1);
        check("t5_ddata", d_rdata, 32'hA5A5A5E5);
        check("t5_ddone", d_done, 1);

        // Data request withdrawn while a fetch burst runs
        tick;
        f_req = 1; f_addr = 32'h2000; f_size = 2'b01;
        tick;
        check("t6_fgnt", f_gnt, 1);
        f_req = 0;
        tick;
        d_req = 1; d_rw = 1; d_addr = 32'h300; d_size = 0;
        dg = 0;
        repeat (2) begin
            tick;
            if (d_gnt) dg++;
        end
        d_req = 0;
        repeat (10) begin
            tick;
            if (d_gnt) dg++;
        end
        check("t6_no_dgnt", dg, 0);
        check("t6_idle", ctrl_busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master controller in front of the byte-addressable 32-bit unified memory.
- Shares the memory between the instruction-fetch port (f_*) and the load/store port (d_*).
- Sequences bursts of 1/4/8/16 words as back-to-back single-word (access_size 00) memory accesses, generating the address for each beat.
- Returns read data with valid/done strobes.

Parameters:
- READ_LAT, 1: cycles from the mem_enable cycle of a read beat to mem_data_out valid.
- STARVE_LIMIT, 4: consecutive lost arbitrations by a pending fetch before fetch is forced to win.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- f_req  in  1  fetch request; held with f_addr/f_size until f_gnt.
- f_addr  in  32  fetch byte address; bits [1:0] ignored.
- f_size  in  2  burst size: 00=1, 01=4, 10=8, 11=16 words.
- f_gnt  out  1  one-cycle pulse: fetch request accepted.
- f_rvalid  out  1  fetch read beat valid.
- f_rdata  out  32  fetch read data.
- f_done  out  1  one-cycle pulse with the last fetch beat.
- d_req  in  1  data request; held with d_rw/d_addr/d_size until d_gnt.
- d_rw  in  1  1=read, 0=write (memory convention).
- d_addr  in  32  data byte address; bits [1:0] ignored.
- d_size  in  2  burst size, same encoding as f_size.
- d_wdata  in  32  write data for the current beat.
- d_wready  out  1  high in each cycle a write beat consumes d_wdata.
- d_gnt  out  1  one-cycle pulse: data request accepted.
- d_rvalid  out  1  data read beat valid.
- d_rdata  out  32  data read data.
- d_done  out  1  one-cycle pulse at end of data burst.
- ctrl_busy  out  1  high whenever state != IDLE.
- mem_addr  out  32  memory address, word aligned.
- mem_data_in  out  32  memory write data.
- mem_access_size  out  2  tied to 00.
- mem_rw  out  1  memory read/write select.
- mem_enable  out  1  memory access strobe, one per beat.
- mem_data_out  in  32  memory read data.

Behaviour:
- Reset (async, any state):
  - All outputs 0; mem_access_size remains 00.
  - State IDLE; beat counter and starve counter cleared.
  - An in-flight burst is aborted and pending read data is discarded: no rvalid or done follows.
- States: IDLE, BURST, DRAIN.
- IDLE, arbitration on each rising edge:
  - Requests are sampled only in IDLE.
  - If only one req is high, that port wins.
  - If both are high, data wins unless the starve counter equals STARVE_LIMIT, in which case fetch wins.
  - Starve counter: +1 when both are high and data wins (saturates at STARVE_LIMIT); cleared on any fetch grant.
  - The winner's addr (with [1:0] forced to 00), size, and rw are latched; fetch rw is always 1.
  - Beats = 1/4/8/16. Next cycle: gnt pulses for 1 cycle and state goes to BURST.
  - A req dropped before gnt is a withdrawal; no grant is issued.
- BURST:
  - Beat k (k=0..beats-1) occupies cycle k after entry.
  - mem_enable=1, mem_rw=latched rw, mem_addr=base+4*k (mod 2^32, wraps at 0xFFFFFFFC->0x00000000).
  - Writes: d_wready=1 and mem_data_in=d_wdata in the same cycle.
  - After the last beat issues: reads go to DRAIN; writes go to IDLE with d_done pulsing in the cycle after the last write beat.
- DRAIN:
  - Waits until the last read beat returns, then IDLE.
  - Read beat issued in cycle t: rvalid=1 and rdata=mem_data_out in cycle t+READ_LAT, on the owner port only.
  - done pulses together with the final rvalid.
- Timing:
  - Single-word read latency, req sampled to rvalid: 2+READ_LAT cycles.
  - Minimum one IDLE cycle between bursts.
  - The other port's req is ignored until IDLE; its gnt never overlaps an active burst.
- Non-owner port outputs (gnt/rvalid/done/wready) stay 0.
- mem_enable is 0 in IDLE and DRAIN.

Test Plan:
- Fetch only, f_addr=0x80020000, f_size=00, mem returns 0xDEADBEEF -> f_gnt at cycle 1; mem_addr=0x80020000 at cycle 2; f_rvalid+f_done with 0xDEADBEEF at cycle 3.
- Data write, d_addr=0x80020013, d_size=01, wdata 1,2,3,4 -> mem_addr 0x80020010/14/18/1C with mem_rw=0 and mem_data_in 1..4 on consecutive cycles; d_wready high 4 cycles; d_done next cycle.
- f_req and d_req held continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,F,D,D,D,D,F; no gnt overlaps a burst.
- Read burst d_size=11 at 0xFFFFFFF0 -> 16 beats, mem_addr wraps to 0x00000000 at beat 4; 16 d_rvalid; d_done only on the 16th.
- Assert reset during beat 5 of an 8-word fetch -> all outputs 0 immediately; no further f_rvalid/f_done; after release, a new d_req is granted normally.
- d_req raised then dropped while a fetch burst is active -> no d_gnt ever issued; return to IDLE with ctrl_busy=0.
